// File: rtl/indicador_jogadores_pkg.sv
// Shared constants and FSM encodings for the player LED indicator.
// The state encodings are also read by the 7-segment debug display decoder.
package indicador_jogadores_pkg;

    localparam int N_JOGADORES = 5;

    localparam logic [2:0] JOGADOR_NENHUM = 3'd7;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ACESO   = 2'd1,
        APAGADO = 2'd2,
        FIM     = 2'd3
    } estado_t;

endpackage

// File: rtl/indicador_jogadores_divisor_pisca.sv
// Free-running cycle divider: counts 0..DIV-1 while enabled and flags the terminal count.
// Used both as the idle blink timebase and as the reveal phase timer.
module divisor_pisca #(
    parameter int DIV = 25000000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] TERMINAL = W'(DIV - 1);

    logic [W-1:0] contador;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contador <= '0;
        end else if (clear) begin
            contador <= '0;
        end else if (enable) begin
            contador <= (contador == TERMINAL) ? '0 : contador + 1'b1;
        end
    end

    assign tick = enable && (contador == TERMINAL);

endmodule

// File: rtl/indicador_jogadores.sv
// One LED per player seat: solid for alive, blinking for the current turn, dark for dead,
// plus a reveal mode that flashes only the eliminated player's LED a fixed number of times.
module indicador_jogadores #(
    parameter int N_JOGADORES = indicador_jogadores_pkg::N_JOGADORES,
    parameter int DIV_PISCA   = 25000000,
    parameter int N_PISCADAS  = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [2:0]             jogador_atual,
    input  logic                   mostra_turno,
    input  logic [N_JOGADORES-1:0] mortes,
    input  logic                   revelar,
    input  logic [2:0]             eliminado,
    output logic [N_JOGADORES-1:0] leds_jogadores,
    output logic                   revelando,
    output logic                   fim_revelacao,
    output logic [1:0]             db_estado
);

    import indicador_jogadores_pkg::*;

    // One extra bit so the flash count can represent N_PISCADAS itself, even when it is 1.
    localparam int WP = $clog2(N_PISCADAS + 1);
    localparam logic [WP-1:0] ULTIMA_PISCADA = WP'(N_PISCADAS - 1);

    estado_t                estado, estado_prox;
    logic                   fase;
    logic [2:0]             indice;
    logic [WP-1:0]          piscadas;
    logic                   tick_base, tick_fase;
    logic                   aceita_revelar;
    logic                   em_ocioso;
    logic [N_JOGADORES-1:0] leds_ocioso, leds_revela;

    assign em_ocioso      = (estado == OCIOSO) || (estado == FIM);
    assign aceita_revelar = (estado == OCIOSO) && revelar;

    divisor_pisca #(.DIV(DIV_PISCA)) u_base (
        .clock  (clock),
        .reset  (reset),
        .enable (em_ocioso),
        .clear  (1'b0),
        .tick   (tick_base)
    );

    divisor_pisca #(.DIV(DIV_PISCA)) u_fase (
        .clock  (clock),
        .reset  (reset),
        .enable (estado == ACESO || estado == APAGADO),
        .clear  (aceita_revelar),
        .tick   (tick_fase)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= OCIOSO;
            fase     <= 1'b0;
            indice   <= JOGADOR_NENHUM;
            piscadas <= '0;
        end else begin
            estado <= estado_prox;
            if (tick_base) begin
                fase <= ~fase;
            end
            if (aceita_revelar) begin
                indice   <= eliminado;
                piscadas <= '0;
            end else if (estado == APAGADO && tick_fase) begin
                piscadas <= piscadas + 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_JOGADORES; i++) begin
            leds_ocioso[i] = ~mortes[i];
            if (mostra_turno && jogador_atual == 3'(i) && !mortes[i]) begin
                leds_ocioso[i] = fase;
            end
            // An out-of-range latched index never matches, leaving every LED dark.
            leds_revela[i] = (indice == 3'(i));
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        estado_prox    = estado;
        leds_jogadores = '0;
        revelando      = 1'b0;
        fim_revelacao  = 1'b0;
        case (estado)
            OCIOSO: begin
                leds_jogadores = leds_ocioso;
                if (revelar) begin
                    estado_prox = ACESO;
                end
            end
            ACESO: begin
                leds_jogadores = leds_revela;
                revelando      = 1'b1;
                if (tick_fase) begin
                    estado_prox = APAGADO;
                end
            end
            APAGADO: begin
                revelando = 1'b1;
                if (tick_fase) begin
                    estado_prox = (piscadas == ULTIMA_PISCADA) ? FIM : ACESO;
                end
            end
            FIM: begin
                leds_jogadores = leds_ocioso;
                fim_revelacao  = 1'b1;
                estado_prox    = OCIOSO;
            end
            default: estado_prox = OCIOSO;
        endcase
        // Outputs go dark the moment reset is asserted, not at the next edge.
        if (!reset) begin
            leds_jogadores = '0;
            revelando      = 1'b0;
            fim_revelacao  = 1'b0;
        end
    end

    assign db_estado = estado;

endmodule

// File: doc/indicador_jogadores.md
Name: indicador_jogadores

Overview:
- Output-side counterpart of the button-to-player converter: drives one LED per player seat instead of reading one button per seat.
- Idle mode: solid LED for each alive player, blinking LED for the player whose turn it is (class reveal / night action), dark LED for dead players.
- Reveal mode: on request from the control unit, flashes only the eliminated player's LED a fixed number of times, then returns a one-cycle completion pulse.

Parameters:
- N_JOGADORES, 5, number of player seats and LED width.
- DIV_PISCA, 25000000, clock cycles per blink half-period; minimum 2.
- N_PISCADAS, 3, number of on/off flash pairs in a reveal; minimum 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low; clears all state.
- jogador_atual  in  3  index of the player whose turn it is, 0-based; a value >= N_JOGADORES means no player.
- mostra_turno  in  1  level; 1 = blink the current player's LED in idle mode.
- mortes  in  N_JOGADORES  bit i = 1 means player i is dead.
- revelar  in  1  single-cycle request to start a reveal.
- eliminado  in  3  index of the player to reveal; sampled only when revelar is accepted.
- leds_jogadores  out  N_JOGADORES  LED drive, 1 = lit.
- revelando  out  1  high while a reveal is in progress.
- fim_revelacao  out  1  one-cycle pulse when a reveal finishes.
- db_estado  out  2  current FSM state encoding, for the 7-segment debug display.

Behaviour:
- Reset (reset=0, asynchronous): FSM=OCIOSO, blink counter=0, fase=0, flash counter=0, latched index=7. Outputs: leds_jogadores=0, revelando=0, fim_revelacao=0, db_estado=0.
- Timebase: free-running counter cycles 0..DIV_PISCA-1 and produces a tick at the terminal count. fase toggles on each tick. The timebase runs only in OCIOSO and FIM.
- FSM states and encodings: OCIOSO=0, ACESO=1, APAGADO=2, FIM=3.
- OCIOSO:
  - leds[i] = ~mortes[i].
  - Exception: if mostra_turno=1, i==jogador_atual and mortes[i]=0, then leds[i]=fase.
  - On a clock edge with revelar=1: latch eliminado, clear the phase counter and flash counter, go to ACESO.
- ACESO:
  - Only the latched player's LED is lit; all others are 0, dead or alive.
  - A latched index >= N_JOGADORES gives all LEDs 0 with unchanged timing.
  - After DIV_PISCA cycles in the state, go to APAGADO and clear the phase counter.
- APAGADO:
  - All LEDs are 0. After DIV_PISCA cycles, increment the flash counter.
  - If the new count equals N_PISCADAS, go to FIM; otherwise go to ACESO.
- FIM: lasts exactly 1 cycle. fim_revelacao=1, LEDs follow the OCIOSO rule, then go to OCIOSO.
- revelando=1 in ACESO and APAGADO only.
- A full reveal occupies exactly 2*DIV_PISCA*N_PISCADAS cycles in ACESO/APAGADO, plus 1 cycle in FIM.
- revelar is ignored outside OCIOSO. It is not queued.
- Changes to eliminado during a reveal have no effect. Changes to mortes or jogador_atual during a reveal take effect on return to idle.
- A revelar that coincides with a timebase tick in OCIOSO is accepted. The tick still toggles fase.
- State is registered. leds_jogadores, revelando and fim_revelacao are combinational decodes of the registered state and current inputs. There is no extra output latency.
- Counter widths are $clog2 of their limit, with no wrap-around inside a phase. The phase counter compares against DIV_PISCA-1.
- Reset mid-reveal aborts immediately and produces no fim_revelacao pulse.

Decomposition:
- Shared package holds:
  - N_JOGADORES.
  - JOGADOR_NENHUM=3'd7.
  - The 2-bit state encodings, also used by the debug display decoder.
- Sub-module divisor_pisca (parameter DIV; inputs clock, reset, enable, clear; output tick).
  - Instantiated twice: once as the idle blink timebase, once as the reveal phase timer.
- Everything else (FSM, flash counter, LED decode) is in indicador_jogadores.

Test Plan (DIV_PISCA=4, N_PISCADAS=2):
- Reset release, mortes=00000, mostra_turno=0 -> leds=11111, revelando=0, db_estado=0.
- mortes=00100, mostra_turno=1, jogador_atual=1 -> leds alternate between 11001 and 11011 every 4 cycles; bit 2 stays 0.
- revelar pulse with eliminado=3 at edge E -> from E, leds=01000 for 4 cycles, then 00000 for 4, then 01000 for 4, then 00000 for 4. fim_revelacao=1 exactly once, in cycle 17 after E. revelando=1 for 16 cycles. Then back to the idle pattern.
- Second revelar with eliminado=0 during that reveal, and eliminado changed mid-reveal -> ignored; the revealed LED stays bit 3 and only one fim_revelacao pulse occurs.
- eliminado=5 (out of range) -> leds=00000 for 16 cycles, then a fim_revelacao pulse.
- reset driven to 0 in the middle of ACESO -> all outputs 0 immediately, db_estado=0, and no fim_revelacao after reset is released.
